// File: rtl/truth_table_loader.sv
// truth_table_loader: streams DEPTH entries into a lookup table, then serves
// combinational reads once the whole table has been written.
module truth_table_loader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              loaded,
    output logic              busy,
    output logic [ADDR_W:0]   wr_count,
    output logic              overrun
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              loaded_q, loaded_d, overrun_q, overrun_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        loaded_d  = loaded_q;
        overrun_d = overrun_q;
        mem_d     = mem_q;
        // start outranks any write beat, in every state
        if (start) begin
            state_d   = LOAD;
            ptr_d     = '0;
            cnt_d     = '0;
            loaded_d  = 1'b0;
            overrun_d = 1'b0;
        end else if (wr_valid && state_q == LOAD) begin
            mem_d[ptr_q] = wr_data;
            ptr_d        = ptr_q + 1'b1;
            cnt_d        = cnt_q + 1'b1;
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d  = DONE;
                loaded_d = 1'b1;
            end
        end else if (wr_valid) begin
            overrun_d = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            loaded_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            loaded_q  <= loaded_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end
    assign wr_ready = state_q == LOAD && !start;
    assign busy     = state_q == LOAD;
    assign loaded   = loaded_q;
    assign overrun  = overrun_q;
    assign wr_count = cnt_q;
    assign data     = loaded_q ? mem_q[addr] : '0;
endmodule

// File: tb/tb_truth_table_loader.sv
// tb_truth_table_loader: scenario tasks plus randomized traffic checked
// against a count-indexed model of the loading rules.
module tb_truth_table_loader;
    localparam int AW = 3;
    localparam int DW = 2;
    localparam int DEPTH = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] addr = '0;
    logic wr_ready, loaded, busy, overrun;
    logic [DW-1:0] data;
    logic [AW:0] wr_count;
    int total = 0, bad = 0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] pat [DEPTH] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    int m_cnt;
    bit m_loading, m_loaded, m_ov;

    truth_table_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .addr(addr), .data(data), .loaded(loaded), .busy(busy),
        .wr_count(wr_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_cnt = 0;
        m_loading = 0;
        m_loaded = 0;
        m_ov = 0;
    endtask

    // Drive one cycle of inputs, apply the rules to the model at the edge, return at negedge.
    task automatic cyc(input bit s, input bit v, input logic [DW-1:0] d);
        start = s;
        wr_valid = v;
        wr_data = d;
        @(posedge clk);
        if (s) begin
            m_loading = 1; m_cnt = 0; m_loaded = 0; m_ov = 0;
        end else if (v && m_loading) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            if (m_cnt == DEPTH) begin m_loading = 0; m_loaded = 1; end
        end else if (v) begin
            m_ov = 1;
        end
        @(negedge clk);
        start = 0;
        wr_valid = 0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL rst_loaded: got %0b want 0", loaded); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready: got %0b want 0", wr_ready); end
        total++; if (wr_count !== 4'd0) begin bad++; $display("FAIL rst_wr_count: got %0d want 0", wr_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
        @(negedge clk);
        rst = 0;
        m_reset();
    endtask

    task automatic test_preload();
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            total++; if (data !== 2'b00 || loaded !== 1'b0) begin bad++; $display("FAIL preload_read[%0d]: got data=%0h loaded=%0b want data=0 loaded=0", a, data, loaded); end
        end
        @(negedge clk);
        cyc(0, 1, 2'b01);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL idle_overrun: got %0b want 1", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_full_load();
        cyc(1, 0, 2'b00);
        total++; if (busy !== 1'b1 || overrun !== 1'b0) begin bad++; $display("FAIL load_start: got busy=%0b overrun=%0b want 1 0", busy, overrun); end
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1;
            #1;
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL load_ready[%0d]: got %0b want 1", i, wr_ready); end
            cyc(0, 1, pat[i]);
            total++; if (wr_count !== 4'(m_cnt) || loaded !== m_loaded) begin bad++; $display("FAIL load_beat[%0d]: got cnt=%0d loaded=%0b want cnt=%0d loaded=%0b", i, wr_count, loaded, m_cnt, m_loaded); end
            total++; if (data !== (m_loaded ? m_mem[addr] : 2'b00)) begin bad++; $display("FAIL load_partial_data[%0d]: got %0h", i, data); end
        end
        total++; if (loaded !== 1'b1 || wr_count !== 4'd8 || busy !== 1'b0) begin bad++; $display("FAIL load_done: got loaded=%0b cnt=%0d busy=%0b want 1 8 0", loaded, wr_count, busy); end
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            total++; if (data !== pat[a]) begin bad++; $display("FAIL load_read[%0d]: got %0h want %0h", a, data, pat[a]); end
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        cyc(0, 1, 2'b11);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL done_overrun: got %0b want 1", overrun); end
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            total++; if (data !== m_mem[a]) begin bad++; $display("FAIL overrun_table[%0d]: got %0h want %0h", a, data, m_mem[a]); end
        end
        @(negedge clk);
        cyc(1, 1, 2'b10);
        total++; if (overrun !== 1'b0 || busy !== 1'b1 || wr_count !== 4'd0 || loaded !== 1'b0) begin bad++; $display("FAIL start_wins: got ov=%0b busy=%0b cnt=%0d loaded=%0b want 0 1 0 0", overrun, busy, wr_count, loaded); end
    endtask

    task automatic test_throttled();
        cyc(1, 0, 2'b00);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cyc(0, i % 2 == 0, pat[i / 2]);
            total++; if (wr_count !== 4'(m_cnt)) begin bad++; $display("FAIL throttle_cnt[%0d]: got %0d want %0d", i, wr_count, m_cnt); end
        end
        total++; if (loaded !== 1'b1 || wr_count !== 4'd8) begin bad++; $display("FAIL throttle_done: got loaded=%0b cnt=%0d want 1 8", loaded, wr_count); end
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            total++; if (data !== pat[a]) begin bad++; $display("FAIL throttle_read[%0d]: got %0h want %0h", a, data, pat[a]); end
        end
        @(negedge clk);
    endtask

    task automatic test_restart();
        cyc(1, 0, 2'b00);
        for (int i = 0; i < 4; i++) cyc(0, 1, DW'($urandom));
        start = 1;
        wr_valid = 1;
        #1;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL restart_ready: got %0b want 0", wr_ready); end
        cyc(1, 1, 2'b11);
        total++; if (wr_count !== 4'd0 || busy !== 1'b1) begin bad++; $display("FAIL restart_cnt: got cnt=%0d busy=%0b want 0 1", wr_count, busy); end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, DW'($urandom));
            total++; if (loaded !== m_loaded || wr_count !== 4'(m_cnt)) begin bad++; $display("FAIL restart_beat[%0d]: got loaded=%0b cnt=%0d want %0b %0d", i, loaded, wr_count, m_loaded, m_cnt); end
        end
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            total++; if (data !== m_mem[a]) begin bad++; $display("FAIL restart_read[%0d]: got %0h want %0h", a, data, m_mem[a]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 2'b00);
        for (int i = 0; i < 5; i++) cyc(0, 1, DW'($urandom));
        #2;
        rst = 1;
        #1;
        m_reset();
        total++; if (loaded !== 1'b0 || wr_count !== 4'd0 || busy !== 1'b0 || wr_ready !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL async_rst: got loaded=%0b cnt=%0d busy=%0b ready=%0b ov=%0b want all 0", loaded, wr_count, busy, wr_ready, overrun); end
        start = 1;
        wr_valid = 1;
        @(posedge clk);
        @(negedge clk);
        total++; if (wr_count !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL rst_edge_accept: got cnt=%0d busy=%0b want 0 0", wr_count, busy); end
        start = 0;
        wr_valid = 0;
        rst = 0;
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            total++; if (data !== 2'b00) begin bad++; $display("FAIL rst_read[%0d]: got %0h want 0", a, data); end
        end
        @(negedge clk);
        cyc(0, 0, 2'b00);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_wait: got busy=%0b want 0", busy); end
        cyc(1, 1, 2'b00);
        total++; if (overrun !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL idle_start_wins: got ov=%0b busy=%0b want 0 1", overrun, busy); end
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, DW'($urandom));
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            total++; if (loaded !== 1'b1 || data !== m_mem[a]) begin bad++; $display("FAIL reload_read[%0d]: got %0h loaded=%0b want %0h", a, data, loaded, m_mem[a]); end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit s, v;
            logic [DW-1:0] d;
            s = $urandom_range(0, 15) == 0;
            v = $urandom_range(0, 2) != 0;
            d = DW'($urandom);
            addr = AW'($urandom);
            start = s;
            wr_valid = v;
            #1;
            total++; if (wr_ready !== (m_loading && !s)) begin bad++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, wr_ready, m_loading && !s); end
            cyc(s, v, d);
            total++; if (wr_count !== 4'(m_cnt) || loaded !== m_loaded || busy !== m_loading || overrun !== m_ov) begin bad++; $display("FAIL rnd_state[%0d]: got cnt=%0d ld=%0b busy=%0b ov=%0b want %0d %0b %0b %0b", i, wr_count, loaded, busy, overrun, m_cnt, m_loaded, m_loading, m_ov); end
            total++; if (data !== (m_loaded ? m_mem[addr] : 2'b00)) begin bad++; $display("FAIL rnd_data[%0d]: addr=%0d got %0h want %0h", i, addr, data, m_loaded ? m_mem[addr] : 2'b00); end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_preload();
        test_full_load();
        test_overrun();
        test_throttled();
        test_restart();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
